// File: rtl/game_pkg.sv
// Shared types and constants for the LED-and-button game.
// Used by the score path and the autoplay responder.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LED,
        DELAY,
        PRESS,
        RELEASE
    } state_t;

    localparam int NUM_LEDS  = 3;
    localparam int SCORE_MAX = 99;

    function automatic logic is_onehot(input logic [NUM_LEDS-1:0] v);
        return $onehot(v);
    endfunction

endpackage

// File: rtl/reaction_timer.sv
// Counts 100 ms ticks up to the captured reaction delay.
// Holds at the target value instead of wrapping.
module reaction_timer
    import game_pkg::*;
#(
    parameter int DELAY_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               tick,
    input  logic [DELAY_W-1:0] dly,
    output logic               done
);

    logic [DELAY_W-1:0] cnt;

    assign done = (cnt == dly);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (tick && !done) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/auto_player.sv
// Autoplay responder: watches the game LEDs and presses the
// matching button after a tick-counted reaction delay.
module auto_player
    import game_pkg::*;
#(
    parameter int DELAY_W = 4,
    parameter int HIT_MAX = SCORE_MAX
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                tick,
    input  logic [DELAY_W-1:0]  delay,
    input  logic [NUM_LEDS-1:0] led,
    output logic                bOut1,
    output logic                bOut2,
    output logic                bOut3,
    output logic [6:0]          hits,
    output logic                busy
);

    state_t              state;
    logic [NUM_LEDS-1:0] target;
    logic [DELAY_W-1:0]  dly;
    logic                done;
    logic                clear;

    // Counter only runs while in DELAY, so it is always zero on entry.
    assign clear = !enable || (state != DELAY);
    assign busy  = (state == DELAY) || (state == PRESS);

    reaction_timer #(
        .DELAY_W(DELAY_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .tick (tick),
        .dly  (dly),
        .done (done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            target <= '0;
            dly    <= '0;
            hits   <= '0;
            bOut1  <= 1'b0;
            bOut2  <= 1'b0;
            bOut3  <= 1'b0;
        end else begin
            {bOut3, bOut2, bOut1} <= '0;
            // The pulse was already issued on PRESS entry, so count it
            // even if enable drops during PRESS.
            if (state == PRESS && hits < 7'(HIT_MAX)) begin
                hits <= hits + 7'd1;
            end
            if (!enable) begin
                state  <= IDLE;
                target <= '0;
            end else begin
                unique case (state)
                    IDLE: state <= WAIT_LED;
                    WAIT_LED: begin
                        if (is_onehot(led)) begin
                            target <= led;
                            dly    <= delay;
                            state  <= DELAY;
                        end
                    end
                    DELAY: begin
                        if (led != target) begin
                            state <= WAIT_LED;
                        end else if (done) begin
                            state <= PRESS;
                            {bOut3, bOut2, bOut1} <= target;
                        end
                    end
                    PRESS: state <= RELEASE;
                    RELEASE: begin
                        if (led != target) begin
                            state <= WAIT_LED;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
